tetris_move_scheduler: RTL and testbench

- Game-sequencing controller between the button front-end and the board/collision datapath of mini_tetris_top.
- Generates the gravity tick and arbitrates gravity against player moves, issuing one board check at a time.
- Sequences the piece life-cycle: spawn, fall, lock, line-clear, score update, win or game-over.
- Owns piece_active, score and win.

---
 rtl/tetris_move_scheduler_pkg.sv | 25 ++
 rtl/tetris_drop_timer.sv | 30 +++
 rtl/tetris_move_scheduler.sv | 170 +++++++++++++++++
 tb/tb_tetris_move_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_move_scheduler_pkg.sv
// Shared encodings for the move scheduler: board-check opcodes, FSM states
// and default timing/scoring constants.
package tetris_pkg;

  localparam int DROP_TICKS_DEF = 50_000_000;
  localparam int WIN_SCORE_DEF  = 10;
  localparam int DROP_CNT_W     = 27;

  localparam logic [1:0] OP_DOWN  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    CHECK = 3'd3,
    LOCK  = 3'd4,
    CLEAR = 3'd5,
    WIN   = 3'd6,
    OVER  = 3'd7
  } state_t;

endpackage

// File: rtl/tetris_drop_timer.sv
// Gravity counter: counts while run is high, restarts on clr, and flags
// the cycle it reaches DROP_TICKS-1 (where it wraps to zero).
module tetris_drop_timer
  import tetris_pkg::*;
#(
  parameter int DROP_TICKS = DROP_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  clr,
  output logic                  tick,
  output logic [DROP_CNT_W-1:0] cnt
);

  localparam logic [DROP_CNT_W-1:0] LAST = DROP_CNT_W'(DROP_TICKS - 1);

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tetris_move_scheduler.sv
// Piece life-cycle sequencer: arbitrates gravity and player moves into one
// board check at a time, then drives lock, line-clear, scoring and respawn.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int DROP_TICKS = DROP_TICKS_DEF,
  parameter int WIN_SCORE  = WIN_SCORE_DEF,
  parameter int SCORE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_rot,
  input  logic                  btn_down,
  output logic                  chk_req,
  output logic [1:0]            chk_op,
  input  logic                  chk_done,
  input  logic                  chk_ok,
  output logic                  lock_req,
  output logic                  clear_req,
  input  logic                  clear_done,
  input  logic [2:0]            lines_cleared,
  output logic                  spawn_req,
  input  logic                  spawn_done,
  input  logic                  spawn_blocked,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  piece_active,
  output logic [SCORE_W-1:0]    score,
  output logic                  win,
  output logic                  game_over,
  output state_t                state_dbg
);

  // Handshakes: each *_req is a one-cycle pulse; the matching *_done pulse is
  // only honoured while the FSM waits in the corresponding state, and status
  // inputs (chk_ok, lines_cleared, spawn_blocked) are sampled with their done.

  state_t state;
  logic   grav_pend, rot_pend, left_pend, right_pend;
  logic   tick, run;
  logic   spawn_entry;
  logic   win_hit;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_new;

  assign run       = (state == IDLE) || (state == FALL) || (state == CHECK);
  assign state_dbg = state;

  tetris_drop_timer #(.DROP_TICKS(DROP_TICKS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (btn_down),
    .tick (tick),
    .cnt  (drop_cnt)
  );

  always_comb begin
    score_sum   = {1'b0, score} + (SCORE_W+1)'(lines_cleared);
    score_new   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    win_hit     = score_new >= SCORE_W'(WIN_SCORE);
    spawn_entry = ((state == IDLE) && tick) ||
                  ((state == CLEAR) && clear_done && !win_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grav_pend    <= 1'b0;
      rot_pend     <= 1'b0;
      left_pend    <= 1'b0;
      right_pend   <= 1'b0;
      chk_req      <= 1'b0;
      chk_op       <= OP_DOWN;
      lock_req     <= 1'b0;
      clear_req    <= 1'b0;
      spawn_req    <= 1'b0;
      piece_active <= 1'b0;
      score        <= '0;
      win          <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      chk_req   <= 1'b0;
      lock_req  <= 1'b0;
      clear_req <= 1'b0;
      spawn_req <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            state     <= SPAWN;
            spawn_req <= 1'b1;
          end
        end
        FALL: begin
          if (grav_pend || rot_pend || left_pend || right_pend) begin
            chk_req <= 1'b1;
            state   <= CHECK;
            if (grav_pend) begin
              chk_op    <= OP_DOWN;
              grav_pend <= 1'b0;
            end else if (rot_pend) begin
              chk_op   <= OP_ROT;
              rot_pend <= 1'b0;
            end else if (left_pend) begin
              chk_op    <= OP_LEFT;
              left_pend <= 1'b0;
            end else begin
              chk_op     <= OP_RIGHT;
              right_pend <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (chk_done) begin
            if ((chk_op == OP_DOWN) && !chk_ok) begin
              state        <= LOCK;
              lock_req     <= 1'b1;
              piece_active <= 1'b0;
            end else begin
              state <= FALL;
            end
          end
        end
        LOCK: begin
          clear_req <= 1'b1;
          state     <= CLEAR;
        end
        CLEAR: begin
          if (clear_done) begin
            score <= score_new;
            if (win_hit) begin
              state <= WIN;
              win   <= 1'b1;
            end else begin
              state     <= SPAWN;
              spawn_req <= 1'b1;
            end
          end
        end
        SPAWN: begin
          if (spawn_done) begin
            if (spawn_blocked) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state        <= FALL;
              piece_active <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // New pulses override the issue-time clear; SPAWN entry overrides both.
      if (tick || btn_down) grav_pend  <= 1'b1;
      if (btn_rot)          rot_pend   <= 1'b1;
      if (btn_left)         left_pend  <= 1'b1;
      if (btn_right)        right_pend <= 1'b1;
      if (spawn_entry) begin
        grav_pend  <= 1'b0;
        rot_pend   <= 1'b0;
        left_pend  <= 1'b0;
        right_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler with a small gravity period;
// expected check opcodes are queued by the stimulus and checked by a monitor.
module tb_tetris_move_scheduler;
  import tetris_pkg::*;

  localparam int DT = 200;

  logic        clk, rst;
  logic        btn_left, btn_right, btn_rot, btn_down;
  logic        chk_req, chk_done, chk_ok;
  logic [1:0]  chk_op;
  logic        lock_req, clear_req, clear_done;
  logic [2:0]  lines_cleared;
  logic        spawn_req, spawn_done, spawn_blocked;
  logic [26:0] drop_cnt;
  logic        piece_active, win, game_over;
  logic [7:0]  score;
  state_t      state_dbg;

  tetris_move_scheduler #(.DROP_TICKS(DT), .WIN_SCORE(10), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
    .chk_req(chk_req), .chk_op(chk_op), .chk_done(chk_done), .chk_ok(chk_ok),
    .lock_req(lock_req), .clear_req(clear_req), .clear_done(clear_done),
    .lines_cleared(lines_cleared),
    .spawn_req(spawn_req), .spawn_done(spawn_done), .spawn_blocked(spawn_blocked),
    .drop_cnt(drop_cnt), .piece_active(piece_active), .score(score),
    .win(win), .game_over(game_over), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int chk_cnt  = 0;
  int lock_cnt = 0;
  int spawn_cnt = 0;
  logic [1:0] exp_q[$];
  logic prev_lock = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_lock = 1'b0;
    end else begin
      if (prev_lock) check("clear_after_lock", 32'(clear_req), 32'd1);
      prev_lock = lock_req;
      if (lock_req)  lock_cnt++;
      if (spawn_req) spawn_cnt++;
      if (chk_req) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_chk_req: got op %0d expected no request", chk_op);
        end else begin
          check("chk_op", 32'(chk_op), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Driver tasks
  function automatic logic sel(input int which);
    case (which)
      0:       return chk_req;
      1:       return spawn_req;
      2:       return clear_req;
      default: return lock_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sel(which)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic do_chk(input logic ok);
    wait_for(0, DT + 20, "chk_req_seen");
    chk_done = 1'b1;
    chk_ok   = ok;
    @(negedge clk);
    chk_done = 1'b0;
    chk_ok   = 1'b0;
  endtask

  task automatic do_clear(input logic [2:0] n);
    wait_for(2, 20, "clear_req_seen");
    clear_done    = 1'b1;
    lines_cleared = n;
    @(negedge clk);
    clear_done    = 1'b0;
    lines_cleared = 3'd0;
  endtask

  task automatic do_spawn(input logic blocked);
    wait_for(1, DT + 20, "spawn_req_seen");
    spawn_done    = 1'b1;
    spawn_blocked = blocked;
    @(negedge clk);
    spawn_done    = 1'b0;
    spawn_blocked = 1'b0;
  endtask

  // m = {down, right, left, rot}
  task automatic press(input logic [3:0] m);
    btn_down  = m[3];
    btn_right = m[2];
    btn_left  = m[1];
    btn_rot   = m[0];
    @(negedge clk);
    btn_down = 1'b0; btn_right = 1'b0; btn_left = 1'b0; btn_rot = 1'b0;
  endtask

  task automatic drop_piece(input logic [2:0] n);
    exp_q.push_back(OP_DOWN);
    press(4'b1000);
    do_chk(1'b0);
    do_clear(n);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_chk_req"},   32'(chk_req),      32'd0);
    check({tag, "_spawn_req"}, 32'(spawn_req),    32'd0);
    check({tag, "_lock_req"},  32'(lock_req | clear_req), 32'd0);
    check({tag, "_active"},    32'(piece_active), 32'd0);
    check({tag, "_score"},     32'(score),        32'd0);
    check({tag, "_win"},       32'(win | game_over), 32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt),     32'd0);
    check({tag, "_state"},     32'(state_dbg),    32'(IDLE));
  endtask

  int base;

  initial begin
    rst = 1'b1;
    btn_left = 0; btn_right = 0; btn_rot = 0; btn_down = 0;
    chk_done = 0; chk_ok = 0; clear_done = 0; lines_cleared = 0;
    spawn_done = 0; spawn_blocked = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // First piece after the initial gravity wrap in IDLE
    do_spawn(1'b0);
    check("spawn_active", 32'(piece_active), 32'd1);
    check("spawn_score",  32'(score),        32'd0);
    check("spawn_win",    32'(win),          32'd0);

    // Natural gravity wrap in FALL gives a DOWN check
    exp_q.push_back(OP_DOWN);
    do_chk(1'b1);
    check("grav_back_fall", 32'(state_dbg), 32'(FALL));

    // Blocked DOWN locks, clears zero lines, respawns
    base = lock_cnt;
    drop_piece(3'd0);
    check("lock_once",   32'(lock_cnt - base), 32'd1);
    check("score_zero",  32'(score),           32'd0);
    do_spawn(1'b0);

    // Rotate beats left when pressed together
    base = chk_cnt;
    exp_q.push_back(OP_ROT);
    exp_q.push_back(OP_LEFT);
    press(4'b0011);
    do_chk(1'b1);
    do_chk(1'b1);
    repeat (10) @(negedge clk);
    check("two_chk_req", 32'(chk_cnt - base), 32'd2);

    // Illegal right move is dropped, piece stays in FALL
    exp_q.push_back(OP_RIGHT);
    press(4'b0100);
    do_chk(1'b0);
    check("illegal_right_fall", 32'(state_dbg), 32'(FALL));

    // Ten single-line clears reach the win score
    for (int i = 0; i < 10; i++) begin
      drop_piece(3'd1);
      check("score_step", 32'(score), 32'(i + 1));
      if (i < 9) do_spawn(1'b0);
    end
    base = spawn_cnt;
    press(4'b1111);
    repeat (20) @(negedge clk);
    check("win_flag",     32'(win),              32'd1);
    check("win_no_spawn", 32'(spawn_cnt - base), 32'd0);
    check("win_inactive", 32'(piece_active),     32'd0);

    // Four-line clears: 4, 8, then 12 wins
    apply_reset();
    do_spawn(1'b0);
    for (int k = 0; k < 3; k++) begin
      drop_piece(3'd4);
      check("score_quad", 32'(score), 32'(4 * (k + 1)));
      if (k < 2) do_spawn(1'b0);
    end
    @(negedge clk);
    check("win_quad", 32'(win), 32'd1);

    // Blocked spawn ends the game; buttons then do nothing
    apply_reset();
    do_spawn(1'b1);
    check("over_flag",     32'(game_over),    32'd1);
    check("over_inactive", 32'(piece_active), 32'd0);
    base = chk_cnt;
    press(4'b1111);
    repeat (20) @(negedge clk);
    check("over_no_chk", 32'(chk_cnt - base), 32'd0);
    check("over_sticky", 32'(game_over),      32'd1);

    // Reset during CHECK aborts at once; a late chk_done is ignored
    apply_reset();
    do_spawn(1'b0);
    exp_q.push_back(OP_RIGHT);
    press(4'b0100);
    wait_for(0, 20, "rst_chk_req_seen");
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    base = lock_cnt;
    chk_done = 1'b1;
    chk_ok   = 1'b0;
    @(negedge clk);
    chk_done = 1'b0;
    repeat (20) @(negedge clk);
    check("late_done_no_lock", 32'(lock_cnt - base), 32'd0);
    check("late_done_idle",    32'(state_dbg),       32'(IDLE));
    check("exp_q_drained",     32'(exp_q.size()),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
